bullet_engine: RTL and testbench

Bullet engine that owns the table of live projectiles and produces the packed bullet vector consumed by the VGA display stage. It accepts fire requests from the game logic and allocates a free slot for each one. Once per frame it sweeps every slot, advancing active bullets and retiring any that leave the screen. Its output bus connects directly to the display's bullet-contents input.

---
 rtl/bullet_engine.sv | 175 +++++++++++++++++
 tb/tb_bullet_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_engine.sv
// Projectile table: allocates slots on fire requests and sweeps one slot per cycle each frame.
// Optional tank hit detection is compiled in with the BULLET_ENGINE_HIT_EN macro.
module bullet_engine #(
    parameter int MAX_BULLETS  = 64,
    parameter int BULLET_SIZE  = 12,
    parameter int SPRITE_SIZE  = 64,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BULLET_SPEED = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic                     fire_valid,
    output logic                     fire_ready,
    input  logic [9:0]               fire_x,
    input  logic [8:0]               fire_y,
    input  logic [1:0]               fire_dir,
    input  logic                     fire_owner,
    input  logic [9:0]               tank1_x,
    input  logic [9:0]               tank2_x,
    input  logic [8:0]               tank1_y,
    input  logic [8:0]               tank2_y,
    output logic [32*MAX_BULLETS-1:0] bullets_out,
    output logic [6:0]               active_count,
    output logic                     sweep_busy,
    output logic                     hit_p1,
    output logic                     hit_p2
);

    localparam int IDX_W = (MAX_BULLETS > 1) ? $clog2(MAX_BULLETS) : 1;
    localparam logic [10:0] SPD11 = 11'(BULLET_SPEED);
    localparam logic [10:0] SZ11  = 11'(BULLET_SIZE);
    localparam logic [10:0] SW11  = 11'(SCREEN_W);
    localparam logic [10:0] SH11  = 11'(SCREEN_H);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tick_pending_q, tick_pending_d;
    logic [6:0]        count_q, count_d;
    logic              hit_p1_q, hit_p1_d;
    logic              hit_p2_q, hit_p2_d;
    logic [31:0]       slot_q [MAX_BULLETS];
    logic [31:0]       slot_d [MAX_BULLETS];

    logic [IDX_W-1:0]  free_idx;
    logic [31:0]       cur;
    logic [9:0]        cur_x, nx;
    logic [8:0]        cur_y, ny;
    logic [1:0]        cur_dir;
    logic              cur_owner, cur_act;
    logic              edge_retire, hit;

    assign fire_ready   = (state_q == IDLE) && !frame_tick && !tick_pending_q &&
                          (count_q < 7'(MAX_BULLETS));
    assign active_count = count_q;
    assign sweep_busy   = (state_q == SWEEP);
    assign hit_p1       = hit_p1_q;
    assign hit_p2       = hit_p2_q;

    for (genvar j = 0; j < MAX_BULLETS; j++) begin : g_out
        assign bullets_out[32*j +: 32] = slot_q[j];
    end

    always_comb begin
        free_idx = '0;
        for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
            if (!slot_q[i][2]) free_idx = IDX_W'(i);
        end
    end

    assign cur       = slot_q[idx_q];
    assign cur_x     = cur[31:22];
    assign cur_y     = cur[21:13];
    assign cur_dir   = cur[12:11];
    assign cur_owner = cur[10];
    assign cur_act   = cur[2];

    // Boundary tests are done at 11 bits so the sums cannot wrap.
    always_comb begin
        nx          = cur_x;
        ny          = cur_y;
        edge_retire = 1'b0;
        case (cur_dir)
            2'b00: if ({2'b0, cur_y} < SPD11) edge_retire = 1'b1;
                   else ny = cur_y - 9'(BULLET_SPEED);
            2'b01: if ({1'b0, cur_x} + SPD11 + SZ11 > SW11) edge_retire = 1'b1;
                   else nx = cur_x + 10'(BULLET_SPEED);
            2'b10: if ({2'b0, cur_y} + SPD11 + SZ11 > SH11) edge_retire = 1'b1;
                   else ny = cur_y + 9'(BULLET_SPEED);
            default: if ({1'b0, cur_x} < SPD11) edge_retire = 1'b1;
                   else nx = cur_x - 10'(BULLET_SPEED);
        endcase
    end

`ifdef BULLET_ENGINE_HIT_EN
    logic [10:0] tx, ty;
    always_comb begin
        tx  = {1'b0, cur_owner ? tank1_x : tank2_x};
        ty  = {2'b0, cur_owner ? tank1_y : tank2_y};
        hit = !edge_retire &&
              ({1'b0, nx} < tx + 11'(SPRITE_SIZE)) && (tx < {1'b0, nx} + SZ11) &&
              ({2'b0, ny} < ty + 11'(SPRITE_SIZE)) && (ty < {2'b0, ny} + SZ11);
    end
`else
    logic unused_tanks;
    assign unused_tanks = ^{tank1_x, tank2_x, tank1_y, tank2_y};
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        tick_pending_d = tick_pending_q;
        case (state_q)
            IDLE: if (frame_tick || tick_pending_q) begin
                state_d        = SWEEP;
                idx_d          = '0;
                tick_pending_d = 1'b0;
            end
            default: begin
                if (frame_tick) tick_pending_d = 1'b1;
                if (idx_q == IDX_W'(MAX_BULLETS - 1)) state_d = IDLE;
                else idx_d = idx_q + 1'b1;
            end
        endcase
    end

    // Sweep updates and spawns are mutually exclusive because spawning needs IDLE.
    always_comb begin
        for (int i = 0; i < MAX_BULLETS; i++) slot_d[i] = slot_q[i];
        count_d  = count_q;
        hit_p1_d = 1'b0;
        hit_p2_d = 1'b0;
        if (state_q == SWEEP && cur_act) begin
            if (edge_retire) begin
                slot_d[idx_q] = {cur[31:3], 1'b0, cur[1:0]};
                count_d       = count_q - 7'd1;
            end else if (hit) begin
                slot_d[idx_q] = {nx, ny, cur_dir, cur_owner, 7'b0, 1'b0, 2'b0};
                count_d       = count_q - 7'd1;
                hit_p1_d      = cur_owner;
                hit_p2_d      = !cur_owner;
            end else begin
                slot_d[idx_q] = {nx, ny, cur_dir, cur_owner, 7'b0, 1'b1, 2'b0};
            end
        end else if (fire_valid && fire_ready) begin
            slot_d[free_idx] = {fire_x, fire_y, fire_dir, fire_owner, 7'b0, 1'b1, 2'b0};
            count_d          = count_q + 7'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            tick_pending_q <= 1'b0;
            count_q        <= '0;
            hit_p1_q       <= 1'b0;
            hit_p2_q       <= 1'b0;
            for (int i = 0; i < MAX_BULLETS; i++) slot_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            tick_pending_q <= tick_pending_d;
            count_q        <= count_d;
            hit_p1_q       <= hit_p1_d;
            hit_p2_q       <= hit_p2_d;
            for (int i = 0; i < MAX_BULLETS; i++) slot_q[i] <= slot_d[i];
        end
    end

endmodule

// File: tb/tb_bullet_engine.sv
// Self-checking bench for bullet_engine: table-driven spawn vectors plus
// hand-written sweep, pending-tick, reset and table-full sequences.
module tb_bullet_engine;

    localparam int MAXB = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic                frame_tick;
    logic                fire_valid;
    logic                fire_ready;
    logic [9:0]          fire_x;
    logic [8:0]          fire_y;
    logic [1:0]          fire_dir;
    logic                fire_owner;
    logic [9:0]          tank1_x, tank2_x;
    logic [8:0]          tank1_y, tank2_y;
    logic [32*MAXB-1:0]  bullets_out;
    logic [6:0]          active_count;
    logic                sweep_busy;
    logic                hit_p1, hit_p2;

    int checks   = 0;
    int failures = 0;

    bullet_engine dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .fire_valid(fire_valid), .fire_ready(fire_ready),
        .fire_x(fire_x), .fire_y(fire_y), .fire_dir(fire_dir), .fire_owner(fire_owner),
        .tank1_x(tank1_x), .tank2_x(tank2_x), .tank1_y(tank1_y), .tank2_y(tank2_y),
        .bullets_out(bullets_out), .active_count(active_count),
        .sweep_busy(sweep_busy), .hit_p1(hit_p1), .hit_p2(hit_p2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [9:0]  fx;
        logic [8:0]  fy;
        logic [1:0]  dir;
        logic        own;
        logic        tick;
        logic        exp_ready;
        int          exp_count;
        int          slot;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [31:0] mkWord(input int x, input int y, input int dir,
                                            input int own, input int act);
        return {10'(x), 9'(y), 2'(dir), 1'(own), 7'b0, 1'(act), 2'b0};
    endfunction

    function automatic logic [31:0] slotWord(input int j);
        return bullets_out[32*j +: 32];
    endfunction

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fv, input logic [9:0] fx, input logic [8:0] fy,
                                 input logic [1:0] dir, input logic own, input logic tick);
        fire_valid = fv;
        fire_x     = fx;
        fire_y     = fy;
        fire_dir   = dir;
        fire_owner = own;
        frame_tick = tick;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // One frame tick, then enough cycles for the whole sweep plus the trailing hit pulse.
    task automatic runSweep(output int p1, output int p2);
        p1 = 0;
        p2 = 0;
        frame_tick = 1'b1;
        for (int k = 0; k < 70; k++) begin
            step();
            frame_tick = 1'b0;
            p1 += int'(hit_p1);
            p2 += int'(hit_p2);
        end
        checkOutput("sweep_returns_idle", 32'(sweep_busy), 32'd0);
    endtask

    initial begin
        int  n, p1, p2, ready_low;
        logic hist [200];
        int  run1, gap, run2, tail;

        reset   = 1'b1;
        tank1_x = 10'd500; tank1_y = 9'd0;
        tank2_x = 10'd300; tank2_y = 9'd200;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);

        vecs[0] = '{1'b1, 10'd100, 9'd200, 2'b01, 1'b0, 1'b0, 1'b1, 1, 0, mkWord(100, 200, 1, 0, 1)};
        vecs[1] = '{1'b1, 10'd50,  9'd300, 2'b00, 1'b1, 1'b0, 1'b1, 2, 1, mkWord(50, 300, 0, 1, 1)};
        vecs[2] = '{1'b1, 10'd626, 9'd10,  2'b01, 1'b0, 1'b0, 1'b1, 3, 2, mkWord(626, 10, 1, 0, 1)};
        vecs[3] = '{1'b1, 10'd5,   9'd40,  2'b11, 1'b1, 1'b0, 1'b1, 4, 3, mkWord(5, 40, 3, 1, 1)};
        vecs[4] = '{1'b1, 10'd200, 9'd464, 2'b10, 1'b0, 1'b0, 1'b1, 5, 4, mkWord(200, 464, 2, 0, 1)};
        vecs[5] = '{1'b0, 10'd0,   9'd0,   2'b00, 1'b0, 1'b0, 1'b1, 5, 5, 32'd0};
        vecs[6] = '{1'b1, 10'd7,   9'd7,   2'b00, 1'b0, 1'b1, 1'b0, 5, 5, 32'd0};

        step();
        step();
        checkOutput("reset_bullets_zero", 32'(|bullets_out), 32'd0);
        checkOutput("reset_count", 32'(active_count), 32'd0);
        checkOutput("reset_busy", 32'(sweep_busy), 32'd0);
        checkOutput("reset_hits", 32'({hit_p1, hit_p2}), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("reset_ready", 32'(fire_ready), 32'd1);

        // Spawn vectors; the last row collides a fire with a frame tick.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].fv, vecs[i].fx, vecs[i].fy, vecs[i].dir, vecs[i].own, vecs[i].tick);
            #1;
            checkOutput($sformatf("vec%0d_ready", i), 32'(fire_ready), 32'(vecs[i].exp_ready));
            step();
            applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d_count", i), 32'(active_count), 32'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d_slot", i), slotWord(vecs[i].slot), vecs[i].exp_word);
        end

        // First sweep: slot 0 updates two cycles after the tick, busy lasts MAXB cycles.
        checkOutput("sweep1_busy_rise", 32'(sweep_busy), 32'd1);
        checkOutput("sweep1_slot0_not_yet", slotWord(0), mkWord(100, 200, 1, 0, 1));
        step();
        checkOutput("sweep1_slot0_moved", slotWord(0), mkWord(104, 200, 1, 0, 1));
        n = 1;
        while (sweep_busy && n < 200) begin
            n++;
            step();
        end
        checkOutput("sweep1_busy_len", 32'(n), 32'(MAXB));
        checkOutput("sweep1_slot1_up", slotWord(1), mkWord(50, 296, 0, 1, 1));
        checkOutput("sweep1_slot2_retired", slotWord(2), mkWord(626, 10, 1, 0, 0));
        checkOutput("sweep1_slot3_left", slotWord(3), mkWord(1, 40, 3, 1, 1));
        checkOutput("sweep1_slot4_down_edge", slotWord(4), mkWord(200, 468, 2, 0, 1));
        checkOutput("sweep1_count", 32'(active_count), 32'd4);
        checkOutput("sweep1_ready_after", 32'(fire_ready), 32'd1);

        runSweep(p1, p2);
        checkOutput("sweep2_slot3_retired", slotWord(3), mkWord(1, 40, 3, 1, 0));
        checkOutput("sweep2_slot4_retired", slotWord(4), mkWord(200, 468, 2, 0, 0));
        checkOutput("sweep2_count", 32'(active_count), 32'd2);
        checkOutput("sweep2_no_hits", 32'(p1 + p2), 32'd0);

        runSweep(p1, p2);
        checkOutput("sweep3_slot0", slotWord(0), mkWord(112, 200, 1, 0, 1));
        checkOutput("sweep3_slot1", slotWord(1), mkWord(50, 288, 0, 1, 1));
        checkOutput("sweep3_count", 32'(active_count), 32'd2);

        // Owner-0 bullet that moves into tank 2; reuses the lowest free slot (2).
        applyStimulus(1'b1, 10'd286, 9'd220, 2'b01, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("hit_spawn_slot2", slotWord(2), mkWord(286, 220, 1, 0, 1));
        runSweep(p1, p2);
        checkOutput("hit_slot0_no_false_hit", slotWord(0), mkWord(116, 200, 1, 0, 1));
        checkOutput("hit_p1_pulses", 32'(p1), 32'd0);
`ifdef BULLET_ENGINE_HIT_EN
        checkOutput("hit_slot2_retired", slotWord(2), mkWord(290, 220, 1, 0, 0));
        checkOutput("hit_p2_pulses", 32'(p2), 32'd1);
        checkOutput("hit_count", 32'(active_count), 32'd2);
`else
        checkOutput("passthru_slot2_active", slotWord(2), mkWord(290, 220, 1, 0, 1));
        checkOutput("passthru_p2_pulses", 32'(p2), 32'd0);
        checkOutput("passthru_count", 32'(active_count), 32'd3);
`endif

        // Two ticks mid-sweep collapse into one pending sweep after a single idle cycle.
        frame_tick = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step();
            hist[k] = sweep_busy;
            frame_tick = (k == 10 || k == 11);
        end
        run1 = 0; gap = 0; run2 = 0; tail = 0;
        for (int k = 0; k < 64; k++)    run1 += int'(hist[k]);
        gap = int'(hist[64]);
        for (int k = 65; k < 129; k++)  run2 += int'(hist[k]);
        for (int k = 129; k < 200; k++) tail += int'(hist[k]);
        checkOutput("pending_first_sweep_len", 32'(run1), 32'd64);
        checkOutput("pending_gap_busy", 32'(gap), 32'd0);
        checkOutput("pending_second_sweep_len", 32'(run2), 32'd64);
        checkOutput("pending_no_third_sweep", 32'(tail), 32'd0);

        // Asynchronous reset in the middle of a sweep.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int k = 0; k < 5; k++) step();
        checkOutput("midreset_busy_before", 32'(sweep_busy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midreset_bullets_zero", 32'(|bullets_out), 32'd0);
        checkOutput("midreset_count", 32'(active_count), 32'd0);
        checkOutput("midreset_busy", 32'(sweep_busy), 32'd0);
        step();
        reset = 1'b0;
        #1;
        checkOutput("midreset_ready", 32'(fire_ready), 32'd1);

        // Fill every slot, then a 65th request must be ignored.
        ready_low = 0;
        for (int i = 0; i < MAXB; i++) begin
            applyStimulus(1'b1, 10'(i * 8), 9'd100, 2'b01, 1'(i & 1), 1'b0);
            #1;
            if (!fire_ready) ready_low++;
            step();
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("fill_ready_while_filling", 32'(ready_low), 32'd0);
        checkOutput("fill_ready_full", 32'(fire_ready), 32'd0);
        checkOutput("fill_count", 32'(active_count), 32'd64);
        checkOutput("fill_slot0", slotWord(0), mkWord(0, 100, 1, 0, 1));
        checkOutput("fill_slot63", slotWord(63), mkWord(504, 100, 1, 1, 1));
        applyStimulus(1'b1, 10'd7, 9'd7, 2'b10, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("overfill_count", 32'(active_count), 32'd64);
        checkOutput("overfill_slot0", slotWord(0), mkWord(0, 100, 1, 0, 1));
        checkOutput("overfill_slot63", slotWord(63), mkWord(504, 100, 1, 1, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
